// File: rtl/exec_seq_pkg.sv
// Shared encodings for the execution sequencer: op classes, FSM states, timeout width.
package exec_seq_pkg;

    localparam int unsigned TMO_W = 8;

    localparam logic [2:0] OP_ALU   = 3'd0;
    localparam logic [2:0] OP_SHIFT = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_STORE = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LDB,
        S_EXE,
        S_SEXE,
        S_MRST,
        S_MWAIT,
        S_MWA,
        S_MWQ,
        S_LADDR,
        S_MRD,
        S_LWB,
        S_SADDR,
        S_SDATA,
        S_MWR,
        S_ERR
    } state_e;

    // Register index to one-hot select line.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/exec_sequencer_timeout.sv
// Wait-state cycle counter; expire flags the limit-th consecutive waiting cycle.
module seq_timeout_counter
    import exec_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [TMO_W-1:0] i_limit,
    output logic             o_expire_c
);

    logic [TMO_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TMO_W'(1);
        end
    end

    assign o_expire_c = i_enable && (r_count == (i_limit - TMO_W'(1)));

endmodule

// File: rtl/exec_sequencer.sv
// Moore control sequencer driving datapath gates/strobes for one decoded instruction.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned MUL_TIMEOUT = 40
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [2:0] rs,
    input  logic [2:0] rd,
    input  logic       mem_ready,
    input  logic       mul_done,
    output logic [7:0] ra_sel,
    output logic [7:0] sr_sel,
    output logic       SB0,
    output logic       B0B,
    output logic       MMD,
    output logic       SMD,
    output logic       MDA,
    output logic       MDM,
    output logic       SMA,
    output logic       SHS,
    output logic       ALS_H4,
    output logic       ALS_H6_a,
    output logic       ALS_H6_q,
    output logic       Rst_H6,
    output logic       mem_req,
    output logic       mem_we,
    output logic       EX0,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_e           r_state;
    state_e           w_next_state;
    logic [2:0]       r_op;
    logic [2:0]       r_rs;
    logic [2:0]       r_rd;
    logic [2:0]       w_rd_p1;
    logic             w_wait;
    logic             w_expire;
    logic [TMO_W-1:0] w_limit;

    assign w_rd_p1 = r_rd + 3'd1;
    assign w_limit = (r_state == S_MWAIT) ? TMO_W'(MUL_TIMEOUT) : TMO_W'(MEM_TIMEOUT);

    seq_timeout_counter u_tmo (
        .clk        (CLK),
        .rst_n      (CLR),
        .i_clear    (!w_wait),
        .i_enable   (w_wait),
        .i_limit    (w_limit),
        .o_expire_c (w_expire)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction fields are captured only on an accepted start.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_op <= '0;
            r_rs <= '0;
            r_rd <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_op <= op;
            r_rs <= rs;
            r_rd <= rd;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wait       = 1'b0;
        ra_sel       = '0;
        sr_sel       = '0;
        SB0          = 1'b0;
        B0B          = 1'b0;
        MMD          = 1'b0;
        SMD          = 1'b0;
        MDA          = 1'b0;
        MDM          = 1'b0;
        SMA          = 1'b0;
        SHS          = 1'b0;
        ALS_H4       = 1'b0;
        ALS_H6_a     = 1'b0;
        ALS_H6_q     = 1'b0;
        Rst_H6       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        EX0          = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_ALU, OP_MUL: w_next_state = S_LDB;
                        OP_SHIFT:       w_next_state = S_SEXE;
                        OP_LOAD:        w_next_state = S_LADDR;
                        OP_STORE:       w_next_state = S_SADDR;
                        default:        w_next_state = S_ERR;
                    endcase
                end
            end
            S_LDB: begin
                ra_sel       = onehot8(r_rs);
                SHS          = 1'b1;
                SB0          = 1'b1;
                w_next_state = (r_op == OP_MUL) ? S_MRST : S_EXE;
            end
            S_EXE: begin
                ra_sel       = onehot8(r_rd);
                B0B          = 1'b1;
                ALS_H4       = 1'b1;
                sr_sel       = onehot8(r_rd);
                EX0          = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            S_SEXE: begin
                ra_sel       = onehot8(r_rd);
                SHS          = 1'b1;
                sr_sel       = onehot8(r_rd);
                EX0          = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            S_MRST: begin
                Rst_H6       = 1'b1;
                w_next_state = S_MWAIT;
            end
            S_MWAIT: begin
                ra_sel = onehot8(r_rd);
                B0B    = 1'b1;
                w_wait = 1'b1;
                if (mul_done) begin
                    w_next_state = S_MWA;
                end else if (w_expire) begin
                    w_next_state = S_ERR;
                end
            end
            S_MWA: begin
                ALS_H6_a     = 1'b1;
                sr_sel       = onehot8(r_rd);
                EX0          = 1'b1;
                w_next_state = S_MWQ;
            end
            S_MWQ: begin
                ALS_H6_q     = 1'b1;
                sr_sel       = onehot8(w_rd_p1);
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            S_LADDR: begin
                ra_sel       = onehot8(r_rs);
                SHS          = 1'b1;
                SMA          = 1'b1;
                w_next_state = S_MRD;
            end
            // MMD follows mem_ready directly so read data is captured in the ready cycle.
            S_MRD: begin
                mem_req = 1'b1;
                MMD     = mem_ready;
                w_wait  = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_LWB;
                end else if (w_expire) begin
                    w_next_state = S_ERR;
                end
            end
            S_LWB: begin
                MDA          = 1'b1;
                SHS          = 1'b1;
                sr_sel       = onehot8(r_rd);
                EX0          = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            S_SADDR: begin
                ra_sel       = onehot8(r_rd);
                SHS          = 1'b1;
                SMA          = 1'b1;
                w_next_state = S_SDATA;
            end
            S_SDATA: begin
                ra_sel       = onehot8(r_rs);
                SHS          = 1'b1;
                SMD          = 1'b1;
                w_next_state = S_MWR;
            end
            S_MWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                MDM     = 1'b1;
                w_wait  = 1'b1;
                if (mem_ready) begin
                    done         = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_expire) begin
                    w_next_state = S_ERR;
                end
            end
            S_ERR: begin
                done         = 1'b1;
                err          = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench: per-cycle expected output vectors queued by stimulus, checked by a monitor.
module tb_exec_sequencer;

    localparam logic [11:0] G_SB0 = 12'h800;
    localparam logic [11:0] G_B0B = 12'h400;
    localparam logic [11:0] G_MMD = 12'h200;
    localparam logic [11:0] G_SMD = 12'h100;
    localparam logic [11:0] G_MDA = 12'h080;
    localparam logic [11:0] G_MDM = 12'h040;
    localparam logic [11:0] G_SMA = 12'h020;
    localparam logic [11:0] G_SHS = 12'h010;
    localparam logic [11:0] G_H4  = 12'h008;
    localparam logic [11:0] G_H6A = 12'h004;
    localparam logic [11:0] G_H6Q = 12'h002;
    localparam logic [11:0] G_RST = 12'h001;

    localparam logic [5:0] F_NONE = 6'h00;
    localparam logic [5:0] F_REQ  = 6'h20;
    localparam logic [5:0] F_WE   = 6'h10;
    localparam logic [5:0] F_EX0  = 6'h08;
    localparam logic [5:0] F_BUSY = 6'h04;
    localparam logic [5:0] F_DONE = 6'h02;
    localparam logic [5:0] F_ERR  = 6'h01;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       start;
    logic [2:0] op;
    logic [2:0] rs;
    logic [2:0] rd;
    logic       mem_ready;
    logic       mul_done;
    logic [7:0] ra_sel;
    logic [7:0] sr_sel;
    logic       SB0, B0B, MMD, SMD, MDA, MDM, SMA, SHS;
    logic       ALS_H4, ALS_H6_a, ALS_H6_q, Rst_H6;
    logic       mem_req, mem_we, EX0, busy, done, err;

    logic [33:0] act;
    logic [33:0] sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 CLK = ~CLK;

    exec_sequencer #(
        .MEM_TIMEOUT (15),
        .MUL_TIMEOUT (40)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .start     (start),
        .op        (op),
        .rs        (rs),
        .rd        (rd),
        .mem_ready (mem_ready),
        .mul_done  (mul_done),
        .ra_sel    (ra_sel),
        .sr_sel    (sr_sel),
        .SB0       (SB0),
        .B0B       (B0B),
        .MMD       (MMD),
        .SMD       (SMD),
        .MDA       (MDA),
        .MDM       (MDM),
        .SMA       (SMA),
        .SHS       (SHS),
        .ALS_H4    (ALS_H4),
        .ALS_H6_a  (ALS_H6_a),
        .ALS_H6_q  (ALS_H6_q),
        .Rst_H6    (Rst_H6),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .EX0       (EX0),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    assign act = {ra_sel, sr_sel, SB0, B0B, MMD, SMD, MDA, MDM, SMA, SHS,
                  ALS_H4, ALS_H6_a, ALS_H6_q, Rst_H6,
                  mem_req, mem_we, EX0, busy, done, err};

    // Expected vector for one busy cycle.
    function automatic logic [33:0] ev(input logic [7:0] ra, input logic [7:0] sr,
                                       input logic [11:0] g, input logic [5:0] f);
        return {ra, sr, g, f | F_BUSY};
    endfunction

    task automatic chk(input string name, input logic [33:0] got, input logic [33:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Issue one instruction; handshake pulses in busy cycle hs_cyc; noise keeps start high with junk fields.
    task automatic run_txn(input string name, input logic [2:0] t_op, input logic [2:0] t_rs,
                           input logic [2:0] t_rd, input int n, input int hs_cyc,
                           input bit hs_mul, input bit noise);
        @(posedge CLK); #1;
        start = 1'b1; op = t_op; rs = t_rs; rd = t_rd;
        for (int c = 1; c <= n; c++) begin
            @(posedge CLK); #1;
            if (noise) begin
                start = 1'b1; op = 3'd7; rs = ~t_rs; rd = ~t_rd;
            end else begin
                start = 1'b0;
            end
            mem_ready = !hs_mul && (c == hs_cyc);
            mul_done  = hs_mul && (c == hs_cyc);
        end
        @(posedge CLK); #1;
        start = 1'b0; mem_ready = 1'b0; mul_done = 1'b0;
        chk({name, "_drain"}, 34'(sb.size()), 34'd0);
        sb.delete();
        chk({name, "_idle"}, act, 34'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CLR = 1'b0; start = 1'b0; op = '0; rs = '0; rd = '0;
        mem_ready = 1'b0; mul_done = 1'b0;

        fork
            forever begin
                @(negedge CLK);
                if (CLR && busy) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_busy: got %h want idle", act);
                    end else begin
                        chk("cycle", act, sb.pop_front());
                    end
                end
            end
        join_none

        #1 chk("reset_outputs", act, 34'd0);
        repeat (2) @(posedge CLK);
        #1 CLR = 1'b1;
        chk("after_release", act, 34'd0);

        // MUL start, then async reset during the second MWAIT cycle.
        sb.push_back(ev(8'h01, 8'h00, G_SHS | G_SB0, F_NONE));
        sb.push_back(ev(8'h00, 8'h00, G_RST, F_NONE));
        sb.push_back(ev(8'h80, 8'h00, G_B0B, F_NONE));
        @(posedge CLK); #1;
        start = 1'b1; op = 3'd2; rs = 3'd0; rd = 3'd7;
        for (int c = 1; c <= 4; c++) begin
            @(posedge CLK); #1;
            start = 1'b0;
        end
        CLR = 1'b0;
        #1 chk("reset_mid_mwait", act, 34'd0);
        chk("reset_mid_drain", 34'(sb.size()), 34'd0);
        sb.delete();
        @(posedge CLK); #1 CLR = 1'b1;

        // ALU rs=2 rd=3
        sb.push_back(ev(8'h04, 8'h00, G_SHS | G_SB0, F_NONE));
        sb.push_back(ev(8'h08, 8'h08, G_B0B | G_H4, F_EX0 | F_DONE));
        run_txn("alu", 3'd0, 3'd2, 3'd3, 2, 0, 1'b0, 1'b0);

        // SHIFT rd=6 with start held high throughout
        sb.push_back(ev(8'h40, 8'h40, G_SHS, F_EX0 | F_DONE));
        run_txn("shift", 3'd1, 3'd1, 3'd6, 1, 0, 1'b0, 1'b1);

        // MUL rd=7, mul_done on 5th MWAIT cycle, sr index wraps to 0
        sb.push_back(ev(8'h01, 8'h00, G_SHS | G_SB0, F_NONE));
        sb.push_back(ev(8'h00, 8'h00, G_RST, F_NONE));
        for (int i = 0; i < 5; i++) sb.push_back(ev(8'h80, 8'h00, G_B0B, F_NONE));
        sb.push_back(ev(8'h00, 8'h80, G_H6A, F_EX0));
        sb.push_back(ev(8'h00, 8'h01, G_H6Q, F_DONE));
        run_txn("mul", 3'd2, 3'd0, 3'd7, 9, 7, 1'b1, 1'b0);

        // LOAD rs=1 rd=4, mem_ready on 3rd MRD cycle, start held high
        sb.push_back(ev(8'h02, 8'h00, G_SHS | G_SMA, F_NONE));
        sb.push_back(ev(8'h00, 8'h00, 12'h000, F_REQ));
        sb.push_back(ev(8'h00, 8'h00, 12'h000, F_REQ));
        sb.push_back(ev(8'h00, 8'h00, G_MMD, F_REQ));
        sb.push_back(ev(8'h00, 8'h10, G_MDA | G_SHS, F_EX0 | F_DONE));
        run_txn("load", 3'd3, 3'd1, 3'd4, 5, 4, 1'b0, 1'b1);

        // STORE rs=5 rd=2, memory never ready: 15 request cycles then error
        sb.push_back(ev(8'h04, 8'h00, G_SHS | G_SMA, F_NONE));
        sb.push_back(ev(8'h20, 8'h00, G_SHS | G_SMD, F_NONE));
        for (int i = 0; i < 15; i++) sb.push_back(ev(8'h00, 8'h00, G_MDM, F_REQ | F_WE));
        sb.push_back(ev(8'h00, 8'h00, 12'h000, F_DONE | F_ERR));
        run_txn("store_tmo", 3'd4, 3'd5, 3'd2, 18, 0, 1'b0, 1'b0);

        // STORE rs=3 rd=0, ready in the 15th request cycle wins over timeout
        sb.push_back(ev(8'h01, 8'h00, G_SHS | G_SMA, F_NONE));
        sb.push_back(ev(8'h08, 8'h00, G_SHS | G_SMD, F_NONE));
        for (int i = 0; i < 14; i++) sb.push_back(ev(8'h00, 8'h00, G_MDM, F_REQ | F_WE));
        sb.push_back(ev(8'h00, 8'h00, G_MDM, F_REQ | F_WE | F_DONE));
        run_txn("store_edge", 3'd4, 3'd3, 3'd0, 17, 17, 1'b0, 1'b0);

        // Illegal op
        sb.push_back(ev(8'h00, 8'h00, 12'h000, F_DONE | F_ERR));
        run_txn("illegal", 3'd6, 3'd4, 3'd4, 1, 0, 1'b0, 1'b1);

        // MUL rd=2 with no mul_done: 40 wait cycles then error
        sb.push_back(ev(8'h02, 8'h00, G_SHS | G_SB0, F_NONE));
        sb.push_back(ev(8'h00, 8'h00, G_RST, F_NONE));
        for (int i = 0; i < 40; i++) sb.push_back(ev(8'h04, 8'h00, G_B0B, F_NONE));
        sb.push_back(ev(8'h00, 8'h00, 12'h000, F_DONE | F_ERR));
        run_txn("mul_tmo", 3'd2, 3'd1, 3'd2, 43, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
